line_raster_stream: RTL and testbench
=====================================

// Module: line_raster_stream
// PURPOSE
//  Parametrised Bresenham line rasteriser, successor to draw_line. Takes two endpoints,
//  emits every pixel of the line (all octants) on a valid/ready pixel stream at up to
//  1 pixel/clk. Adds backpressure, abort, optional endpoint skip and screen clipping.
//  Sits between the wireframe/triangle setup logic and the framebuffer write port.
// PARAMETERS
//  COORD_W   10   width of every coordinate port (unsigned)
//  SCREEN_W  640  clip width; pixels with x >= SCREEN_W are suppressed
//  SCREEN_H  480  clip height; pixels with y >= SCREEN_H are suppressed
//  CLIP_EN   1    1 = suppress off-screen pixels; 0 = emit all pixels
// PORTS
//  Clk        in   1        system clock, rising edge
//  Reset_n    in   1        asynchronous, active-low reset
//  Start      in   1        request; sampled only in IDLE
//  Abort      in   1        cancel current line, any state
//  Skip_last  in   1        sampled with Start; 1 = do not emit endpoint (x1,y1)
//  x0,y0      in   COORD_W  start point
//  x1,y1      in   COORD_W  end point
//  Busy       out  1        high in SETUP/RUN
//  Done       out  1        1-cycle pulse when line completes (not on Abort)
//  Pix_valid  out  1        PixX/PixY hold a pixel
//  Pix_ready  in   1        consumer accepts pixel when Pix_valid & Pix_ready
//  PixX,PixY  out  COORD_W  pixel coordinate
//  Pix_last   out  1        qualifies final emitted pixel of the line
// BEHAVIOUR
//  Reset: state=IDLE; Busy, Done, Pix_valid, Pix_last = 0; PixX, PixY = 0.
//  FSM: IDLE -Start-> SETUP -> RUN -(final step)-> DONE -> IDLE. Abort: any -> IDLE next clk.
//  IDLE: latch x0,y0,x1,y1,Skip_last when Start=1. Start while Busy is ignored.
//  SETUP (1 clk): dx=|x1-x0|, dy=-|y1-y0| (COORD_W+1 signed); sx/sy=+1 if end>=start else -1;
//   err=dx+dy (COORD_W+2 signed); cur=(x0,y0). First Pix_valid at Start cycle + 2.
//  RUN step: e2=2*err (COORD_W+3 signed); if e2>=dy {err+=dy; x+=sx}; if e2<=dx {err+=dx;
//   y+=sy}; both apply same clk when both true. Step taken when pixel accepted or suppressed.
//  Emission: pixel cur is shown on Pix_valid unless (CLIP_EN & off-screen) or
//   (Skip_last & cur==end). A suppressed pixel costs 1 clk, Pix_valid=0.
//  Backpressure: while Pix_valid & !Pix_ready, PixX/PixY/Pix_last/err held stable.
//  Termination: when cur==end is accepted or suppressed -> DONE; Done=1 for 1 clk, then IDLE.
//  Pix_last: cur==end (Skip_last=0) or next==end (Skip_last=1); never set on a clipped pixel.
//  Pixel count = max(|dx|,|dy|)+1, minus 1 if Skip_last, minus clipped pixels.
//  Degenerate x0==x1 & y0==y1: 1 pixel with Pix_last; with Skip_last: 0 pixels, Done only.
//  Abort mid-RUN: Pix_valid low next clk, no Done, no Pix_last; Start accepted next clk.
//  Abort and Start in same clk: Abort wins; Start ignored.
//  Reset_n low mid-line: immediate return to reset values, no further pixels.
// STRUCTURE
//  line_raster_pkg: state enum (IDLE,SETUP,RUN,DONE), COORD_W default, signed width
//   localparams (DW=COORD_W+1, EW=COORD_W+2).
//  Sub-module bresenham_step (combinational): (x,y,err,dx,dy,sx,sy) -> (nx,ny,nerr);
//   used for the register update and for the Skip_last look-ahead.
// TESTING
//  1 (10,30)->(40,20), Pix_ready=1 -> 31 pixels, first (10,30), last (40,20) with Pix_last,
//    y steps -1 exactly 10 times, Done 1 clk after last accept.
//  2 (5,5)->(5,0) and (0,0)->(7,7) -> 6 pixels x const / 8 diagonal pixels, each 1 clk apart.
//  3 Case 1 with Pix_ready toggled 1-0-1 every clk -> same 31 pixels in order, outputs stable
//    while stalled, no drops/duplicates.
//  4 (3,3)->(3,3): Skip_last=0 -> 1 pixel+Pix_last; Skip_last=1 -> 0 pixels, Done at Start+3.
//  5 Abort after 4th accepted pixel of case 1 -> Pix_valid=0 next clk, no Done; new Start
//    (0,0)->(2,0) then yields (0,0),(1,0),(2,0).
//  6 CLIP_EN=1, (630,470)->(650,470) -> only x=630..639 emitted, no Pix_last, Done pulses.

Source files
------------

// File: rtl/line_raster_pkg.sv
// Shared types and width defaults for the line rasteriser.
package line_raster_pkg;

    localparam int unsigned COORD_W_DEF = 10;
    localparam int unsigned DW_DEF      = COORD_W_DEF + 1;
    localparam int unsigned EW_DEF      = COORD_W_DEF + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: (x,y,err) -> (nx,ny,nerr) for a fixed dx/dy/direction.
module bresenham_step
    import line_raster_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic signed [COORD_W+1:0] err,
    input  logic signed [COORD_W:0]   dx,
    input  logic signed [COORD_W:0]   dy,
    input  logic                      sx_neg,
    input  logic                      sy_neg,
    output logic [COORD_W-1:0]        nx_c,
    output logic [COORD_W-1:0]        ny_c,
    output logic signed [COORD_W+1:0] nerr_c
);

    localparam int unsigned EW  = COORD_W + 2;
    localparam int unsigned E2W = COORD_W + 3;

    logic signed [E2W-1:0] e2;
    logic signed [E2W-1:0] dx_e;
    logic signed [E2W-1:0] dy_e;
    logic signed [E2W-1:0] acc;
    logic                  step_x;
    logic                  step_y;

    // Both axes may move in the same step; both error updates then accumulate.
    always_comb begin
        e2     = {err, 1'b0};
        dx_e   = E2W'(dx);
        dy_e   = E2W'(dy);
        step_x = (e2 >= dy_e);
        step_y = (e2 <= dx_e);
        acc    = E2W'(err);
        if (step_x) acc = acc + dy_e;
        if (step_y) acc = acc + dx_e;
        nerr_c = EW'(acc);
        nx_c   = x;
        ny_c   = y;
        if (step_x) nx_c = sx_neg ? x - COORD_W'(1) : x + COORD_W'(1);
        if (step_y) ny_c = sy_neg ? y - COORD_W'(1) : y + COORD_W'(1);
    end

endmodule

// File: rtl/line_raster_stream.sv
// Bresenham line rasteriser with valid/ready pixel stream, abort, endpoint skip and clipping.
module line_raster_stream
    import line_raster_pkg::*;
#(
    parameter int unsigned COORD_W  = COORD_W_DEF,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter bit          CLIP_EN  = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Skip_last,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               Busy,
    output logic               Done,
    output logic               Pix_valid,
    input  logic               Pix_ready,
    output logic [COORD_W-1:0] PixX,
    output logic [COORD_W-1:0] PixY,
    output logic               Pix_last
);

    localparam int unsigned DW = COORD_W + 1;
    localparam int unsigned EW = COORD_W + 2;
    localparam logic [DW-1:0] SCR_W = DW'(SCREEN_W);
    localparam logic [DW-1:0] SCR_H = DW'(SCREEN_H);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0]   end_x_q, end_x_d, end_y_q, end_y_d;
    logic [COORD_W-1:0]   nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
    logic signed [EW-1:0] nxt_err_q, nxt_err_d;
    logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                 skip_q, skip_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;

    logic [COORD_W-1:0]   adx, ady;
    logic signed [DW-1:0] setup_dx, setup_dy;
    logic                 setup_sx_neg, setup_sy_neg;

    logic [COORD_W-1:0]   cand_x, cand_y;
    logic signed [EW-1:0] cand_err;
    logic signed [DW-1:0] cand_dx, cand_dy;
    logic                 cand_sx_neg, cand_sy_neg;
    logic [COORD_W-1:0]   look_x_c, look_y_c;
    logic signed [EW-1:0] look_err_c;

    logic                 load, advance, at_end;
    logic                 cand_at_end, look_at_end, cand_off, cand_show, cand_last;

    // Line geometry from the latched endpoints (cur holds the start point during SETUP).
    always_comb begin
        setup_sx_neg = (end_x_q < cur_x_q);
        setup_sy_neg = (end_y_q < cur_y_q);
        adx          = setup_sx_neg ? cur_x_q - end_x_q : end_x_q - cur_x_q;
        ady          = setup_sy_neg ? cur_y_q - end_y_q : end_y_q - cur_y_q;
        setup_dx     = $signed(DW'(adx));
        setup_dy     = -$signed(DW'(ady));
    end

    // Candidate pixel to load: the start point in SETUP, the precomputed next pixel in RUN.
    always_comb begin
        if (state_q == ST_SETUP) begin
            cand_x      = cur_x_q;
            cand_y      = cur_y_q;
            cand_err    = EW'(setup_dx) + EW'(setup_dy);
            cand_dx     = setup_dx;
            cand_dy     = setup_dy;
            cand_sx_neg = setup_sx_neg;
            cand_sy_neg = setup_sy_neg;
        end else begin
            cand_x      = nxt_x_q;
            cand_y      = nxt_y_q;
            cand_err    = nxt_err_q;
            cand_dx     = dx_q;
            cand_dy     = dy_q;
            cand_sx_neg = sx_neg_q;
            cand_sy_neg = sy_neg_q;
        end
    end

    // Stepping the candidate yields both the following pixel and the Skip_last look-ahead.
    bresenham_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .x      (cand_x),
        .y      (cand_y),
        .err    (cand_err),
        .dx     (cand_dx),
        .dy     (cand_dy),
        .sx_neg (cand_sx_neg),
        .sy_neg (cand_sy_neg),
        .nx_c   (look_x_c),
        .ny_c   (look_y_c),
        .nerr_c (look_err_c)
    );

    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;
        nxt_x_d     = nxt_x_q;
        nxt_y_d     = nxt_y_q;
        nxt_err_d   = nxt_err_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        skip_d      = skip_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        load        = 1'b0;

        // A suppressed pixel advances unconditionally; a shown one only on handshake.
        advance     = ~pix_valid_q | Pix_ready;
        at_end      = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
        cand_at_end = (cand_x == end_x_q) && (cand_y == end_y_q);
        look_at_end = (look_x_c == end_x_q) && (look_y_c == end_y_q);
        cand_off    = ({1'b0, cand_x} >= SCR_W) || ({1'b0, cand_y} >= SCR_H);
        cand_show   = ~(CLIP_EN & cand_off) & ~(skip_q & cand_at_end);
        cand_last   = cand_show & (skip_q ? look_at_end : cand_at_end);

        case (state_q)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    cur_x_d = x0;
                    cur_y_d = y0;
                    end_x_d = x1;
                    end_y_d = y1;
                    skip_d  = Skip_last;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dx_d     = setup_dx;
                dy_d     = setup_dy;
                sx_neg_d = setup_sx_neg;
                sy_neg_d = setup_sy_neg;
                load     = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (advance) begin
                    if (at_end) begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            cur_x_d     = cand_x;
            cur_y_d     = cand_y;
            nxt_x_d     = look_x_c;
            nxt_y_d     = look_y_c;
            nxt_err_d   = look_err_c;
            pix_valid_d = cand_show;
            pix_last_d  = cand_last;
        end

        if (Abort) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            nxt_x_q     <= '0;
            nxt_y_q     <= '0;
            nxt_err_q   <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            skip_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            nxt_x_q     <= nxt_x_d;
            nxt_y_q     <= nxt_y_d;
            nxt_err_q   <= nxt_err_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            skip_q      <= skip_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pix_valid = pix_valid_q;
    assign Pix_last  = pix_last_q;
    assign PixX      = cur_x_q;
    assign PixY      = cur_y_q;

endmodule

// File: tb/tb_line_raster_stream.sv
// Self-checking bench: directed line cases plus random lines against a queue-based pixel model.
module tb_line_raster_stream;

    localparam int unsigned COORD_W = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    logic               Clk, Reset_n, Start, Abort, Skip_last, Pix_ready;
    logic [COORD_W-1:0] x0, y0, x1, y1, PixX, PixY;
    logic               Busy, Done, Pix_valid, Pix_last;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    pix_t exp_q[$];
    int   total;
    int   bad;
    int   last_acc;
    int   last_first_cyc;

    line_raster_stream #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .CLIP_EN  (1'b1)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Abort     (Abort),
        .Skip_last (Skip_last),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .Busy      (Busy),
        .Done      (Done),
        .Pix_valid (Pix_valid),
        .Pix_ready (Pix_ready),
        .PixX      (PixX),
        .PixY      (PixY),
        .Pix_last  (Pix_last)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Reference: walk the line point by point, then drop the endpoint (skip) and off-screen pixels.
    task automatic build_expect(input int ax0, input int ay0, input int ax1, input int ay1,
                                input bit skip, output int n_raw);
        int px[$];
        int py[$];
        int x, y, dx, dy, sx, sy, err, e2, keep;
        exp_q.delete();
        dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax1 >= ax0) ? 1 : -1;
        sy  = (ay1 >= ay0) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        for (int s = 0; s < 4096; s++) begin
            px.push_back(x);
            py.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        n_raw = px.size();
        keep  = skip ? n_raw - 1 : n_raw;
        for (int i = 0; i < keep; i++) begin
            if (px[i] < SCREEN_W && py[i] < SCREEN_H)
                exp_q.push_back('{x: px[i], y: py[i], last: (i == keep - 1)});
        end
    endtask

    // Called at a falling edge; returns at a falling edge with the DUT idle.
    // mode: 0 = always ready, 1 = random ready, 2 = toggling ready.
    task automatic run_line(input string tag, input int ax0, input int ay0, input int ax1,
                            input int ay1, input bit skip, input int mode, input int abort_after);
        int n_raw, n_exp, cyc, acc;
        bit done_seen, abort_pend, aborted, rdy;
        build_expect(ax0, ay0, ax1, ay1, skip, n_raw);
        n_exp     = exp_q.size();
        x0        = COORD_W'(ax0);
        y0        = COORD_W'(ay0);
        x1        = COORD_W'(ax1);
        y1        = COORD_W'(ay1);
        Skip_last = skip;
        Start     = 1'b1;
        Pix_ready = 1'b0;
        @(negedge Clk);
        Start     = 1'b0;
        Skip_last = ~skip;
        x0 = COORD_W'($urandom);
        y0 = COORD_W'($urandom);
        x1 = COORD_W'($urandom);
        y1 = COORD_W'($urandom);
        cyc = 1;
        acc = 0;
        done_seen  = 1'b0;
        abort_pend = 1'b0;
        aborted    = 1'b0;
        last_first_cyc = -1;
        check({tag, ":busy_setup"}, 32'(Busy), 1);
        check({tag, ":valid_setup"}, 32'(Pix_valid), 0);
        while (!done_seen && !aborted && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
            if (abort_pend) begin
                Abort     = 1'b1;
                Pix_ready = 1'b0;
                aborted   = 1'b1;
            end else begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = cyc[0];
                endcase
                Pix_ready = rdy;
                if (Done) begin
                    done_seen = 1'b1;
                    check({tag, ":pending_at_done"}, exp_q.size(), 0);
                    check({tag, ":busy_at_done"}, 32'(Busy), 0);
                    if (mode == 0) check({tag, ":done_cycle"}, cyc, 2 + n_raw);
                end else if (Pix_valid) begin
                    if (last_first_cyc < 0) last_first_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check({tag, ":extra_pixel"}, 32'(Pix_valid), 0);
                    end else begin
                        check({tag, ":x"}, 32'(PixX), exp_q[0].x);
                        check({tag, ":y"}, 32'(PixY), exp_q[0].y);
                        check({tag, ":last"}, 32'(Pix_last), 32'(exp_q[0].last));
                        if (rdy) begin
                            void'(exp_q.pop_front());
                            acc++;
                            if (acc == abort_after) abort_pend = 1'b1;
                        end
                    end
                end
            end
        end
        if (aborted) begin
            @(negedge Clk);
            Abort = 1'b0;
            check({tag, ":valid_after_abort"}, 32'(Pix_valid), 0);
            check({tag, ":busy_after_abort"}, 32'(Busy), 0);
            check({tag, ":done_after_abort"}, 32'(Done), 0);
        end else begin
            check({tag, ":done_seen"}, 32'(done_seen), 1);
            check({tag, ":count"}, acc, n_exp);
            @(negedge Clk);
            Pix_ready = 1'b0;
            check({tag, ":done_pulse"}, 32'(Done), 0);
        end
        last_acc = acc;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        Reset_n   = 1'b0;
        Start     = 1'b0;
        Abort     = 1'b0;
        Skip_last = 1'b0;
        Pix_ready = 1'b0;
        x0 = '0;
        y0 = '0;
        x1 = '0;
        y1 = '0;
        repeat (2) @(negedge Clk);
        check("rst:busy", 32'(Busy), 0);
        check("rst:done", 32'(Done), 0);
        check("rst:valid", 32'(Pix_valid), 0);
        check("rst:last", 32'(Pix_last), 0);
        check("rst:pixx", 32'(PixX), 0);
        check("rst:pixy", 32'(PixY), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        run_line("t1", 10, 30, 40, 20, 1'b0, 0, -1);
        check("t1:n", last_acc, 31);
        check("t1:first_cycle", last_first_cyc, 2);
        run_line("t2a", 5, 5, 5, 0, 1'b0, 0, -1);
        check("t2a:n", last_acc, 6);
        run_line("t2b", 0, 0, 7, 7, 1'b0, 0, -1);
        check("t2b:n", last_acc, 8);
        run_line("t3", 10, 30, 40, 20, 1'b0, 2, -1);
        check("t3:n", last_acc, 31);
        run_line("t4a", 3, 3, 3, 3, 1'b0, 0, -1);
        check("t4a:n", last_acc, 1);
        run_line("t4b", 3, 3, 3, 3, 1'b1, 0, -1);
        check("t4b:n", last_acc, 0);
        run_line("t5", 10, 30, 40, 20, 1'b0, 0, 4);
        check("t5:n", last_acc, 4);
        run_line("t5b", 0, 0, 2, 0, 1'b0, 0, -1);
        check("t5b:n", last_acc, 3);
        run_line("t6", 630, 470, 650, 470, 1'b0, 1, -1);
        check("t6:n", last_acc, 10);
        run_line("t7", 40, 20, 10, 30, 1'b1, 1, -1);
        check("t7:n", last_acc, 30);

        // Abort and Start together: Abort wins, nothing starts.
        x0 = 10'd1; y0 = 10'd1; x1 = 10'd9; y1 = 10'd4;
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Abort = 1'b0;
        check("abort_start:busy", 32'(Busy), 0);
        @(negedge Clk);
        check("abort_start:busy2", 32'(Busy), 0);
        check("abort_start:valid", 32'(Pix_valid), 0);

        // Reset asserted in the middle of a line.
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd100; y1 = 10'd50;
        Start     = 1'b1;
        Pix_ready = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        check("rst_mid:valid_before", 32'(Pix_valid), 1);
        Reset_n = 1'b0;
        #1;
        check("rst_mid:valid", 32'(Pix_valid), 0);
        check("rst_mid:busy", 32'(Busy), 0);
        check("rst_mid:pixx", 32'(PixX), 0);
        check("rst_mid:pixy", 32'(PixY), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("rst_mid:idle_valid", 32'(Pix_valid), 0);
            check("rst_mid:idle_busy", 32'(Busy), 0);
        end
        Pix_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int ax, ay, bx, by, bsx, bsy;
            if (i % 2 == 0) begin
                bsx = 600;
                bsy = 440;
            end else begin
                bsx = 0;
                bsy = 0;
            end
            ax = bsx + int'($urandom_range(0, 80));
            ay = bsy + int'($urandom_range(0, 80));
            bx = bsx + int'($urandom_range(0, 80));
            by = bsy + int'($urandom_range(0, 80));
            if ($urandom_range(0, 7) == 0) begin
                bx = ax;
                by = ay;
            end
            run_line("rand", ax, ay, bx, by, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
